// File: rtl/ram_port_controller.sv
// Initiator-side controller for the single-port ram_32x16: serialises read, write and fill
// requests onto the RAM pins and returns one registered response per request.
module ram_port_controller #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [ADDR_W-1:0] req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              ram_write_enable,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPTURE,
    WR,
    FILL,
    RESP
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] fill_remaining;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      fill_remaining   <= '0;
      rsp_valid        <= 1'b0;
      rsp_rdata        <= '0;
      rsp_err          <= 1'b0;
      ram_write_enable <= 1'b0;
      ram_address      <= '0;
      ram_data_in      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            case (req_op)
              OP_READ: begin
                ram_address <= req_addr;
                state       <= RD_ISSUE;
              end
              OP_WRITE: begin
                ram_write_enable <= 1'b1;
                ram_address      <= req_addr;
                ram_data_in      <= req_wdata;
                state            <= WR;
              end
              OP_FILL: begin
                ram_write_enable <= 1'b1;
                ram_address      <= req_addr;
                ram_data_in      <= req_wdata;
                fill_remaining   <= req_len;
                state            <= FILL;
              end
              default: begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
                state     <= RESP;
              end
            endcase
          end
        end
        // RAM registers the address at the end of RD_ISSUE; its output is valid during RD_CAPTURE.
        RD_ISSUE: state <= RD_CAPTURE;
        RD_CAPTURE: begin
          rsp_rdata <= ram_data_out;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        WR: begin
          ram_write_enable <= 1'b0;
          rsp_valid        <= 1'b1;
          state            <= RESP;
        end
        FILL: begin
          if (fill_remaining == '0) begin
            ram_write_enable <= 1'b0;
            rsp_valid        <= 1'b1;
            state            <= RESP;
          end else begin
            ram_address    <= ram_address + 1'b1;
            fill_remaining <= fill_remaining - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
